// File: rtl/mips_cpu_muldiv_unit_if.sv
// Request/result bundle between the MIPS core and the multiply/divide unit.
// The core drives the request side; the unit drives status and the HI/LO registers.
interface mips_cpu_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator, with architectural HI/LO registers.
module mips_cpu_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic                clk,
   input logic                rst,
   mips_cpu_muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     counter;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd;
   logic                 is_div;
   logic                 neg_lo;
   logic                 neg_hi;
   logic                 div_by_zero;
   logic                 done_q;
   logic                 div_zero_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;

   logic                 accept;
   logic                 move;
   logic                 signed_op;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       trial;
   logic [2*WIDTH-1:0]   prod_fixed;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;

   assign accept    = (state == IDLE) && bus.start && !bus.op[2];
   assign move      = (state == IDLE) && bus.start && (bus.op[2:1] == 2'b10);
   assign signed_op = !bus.op[0];
   assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply adds the multiplicand into the upper half; divide trial-subtracts from the shifted remainder.
   assign add_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
   assign trial      = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
   assign prod_fixed = neg_lo ? -acc : acc;
   assign quo        = div_by_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
   assign rem        = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (counter == CNT_W'(WIDTH - 1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter     <= '0;
         acc         <= '0;
         opnd        <= '0;
         is_div      <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         div_by_zero <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  acc         <= {{WIDTH{1'b0}}, a_mag};
                  opnd        <= b_mag;
                  is_div      <= bus.op[1];
                  neg_lo      <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_hi      <= signed_op && bus.a[WIDTH-1];
                  div_by_zero <= bus.op[1] && (bus.b == '0);
                  div_zero_q  <= 1'b0;
                  counter     <= '0;
               end else if (move) begin
                  if (bus.op[0]) begin
                     lo_q <= bus.a;
                  end else begin
                     hi_q <= bus.a;
                  end
                  done_q <= 1'b1;
               end
            end
            RUN: begin
               counter <= counter + 1'b1;
               if (is_div) begin
                  if (!trial[WIDTH]) begin
                     acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= {acc[2*WIDTH-2:0], 1'b0};
                  end
               end else if (acc[0]) begin
                  acc <= {add_sum, acc[WIDTH-1:1]};
               end else begin
                  acc <= {1'b0, acc[2*WIDTH-1:1]};
               end
            end
            FIX: begin
               // A zero divisor leaves |a| as remainder; re-signing it restores a exactly.
               if (is_div) begin
                  hi_q       <= rem;
                  lo_q       <= quo;
                  div_zero_q <= div_by_zero;
               end else begin
                  {hi_q, lo_q} <= prod_fixed;
               end
               done_q <= 1'b1;
            end
            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Self-checking bench for mips_cpu_muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic model of HI/LO/div_zero.
module tb_mips_cpu_muldiv_unit;

   localparam int WIDTH = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_RSVD  = 3'b110;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   logic [31:0] mHi;
   logic [31:0] mLo;
   logic        mDz;

   always #5 clk = ~clk;

   mips_cpu_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

   mips_cpu_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: MIPS HI/LO semantics computed directly with wide integer arithmetic.
   task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sq;
      int          sr;
      case (op)
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {mHi, mLo} = sp;
            mDz = 1'b0;
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {mHi, mLo} = up;
            mDz = 1'b0;
         end
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               mLo = 32'hFFFF_FFFF;
               mHi = a;
               mDz = 1'b1;
            end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               mLo = 32'h8000_0000;
               mHi = 32'd0;
               mDz = 1'b0;
            end else if (op == OP_DIV) begin
               sq  = $signed(a) / $signed(b);
               sr  = $signed(a) % $signed(b);
               mLo = sq;
               mHi = sr;
               mDz = 1'b0;
            end else begin
               mLo = a / b;
               mHi = a % b;
               mDz = 1'b0;
            end
         end
         OP_MTHI: mHi = a;
         OP_MTLO: mLo = a;
         default: ;
      endcase
   endtask

   // Issues one request; interfereAt>0 pulses a DIVU start at that cycle of the run.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int interfereAt);
      logic [31:0] prevHi;
      logic [31:0] prevLo;
      int          n;
      int          busyCnt;
      prevHi = mHi;
      prevLo = mLo;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      modelOp(op, a, b);
      if (op[2] == 1'b0) begin
         checkOutput("busy_accept", bus.busy, 1);
         checkOutput("dz_clear_accept", bus.div_zero, 0);
         checkOutput("hi_hold_accept", bus.hi, prevHi);
         busyCnt = bus.busy;
         n = 0;
         while (!bus.done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            busyCnt += int'(bus.busy);
            if (bus.start) bus.start = 1'b0;
            if (n == interfereAt) begin
               checkOutput("hi_hold_run", bus.hi, prevHi);
               checkOutput("lo_hold_run", bus.lo, prevLo);
               bus.start = 1'b1;
               bus.op    = OP_DIVU;
               bus.a     = 32'd100;
               bus.b     = 32'd7;
            end
         end
         checkOutput("latency", n, WIDTH + 1);
         checkOutput("busy_cycles", busyCnt, WIDTH + 1);
         checkOutput("busy_end", bus.busy, 0);
         checkOutput("hi", bus.hi, mHi);
         checkOutput("lo", bus.lo, mLo);
         checkOutput("div_zero", bus.div_zero, mDz);
      end else if (op[1] == 1'b0) begin
         checkOutput("mt_done", bus.done, 1);
         checkOutput("mt_busy", bus.busy, 0);
         checkOutput("mt_hi", bus.hi, mHi);
         checkOutput("mt_lo", bus.lo, mLo);
      end else begin
         checkOutput("rsvd_done", bus.done, 0);
         checkOutput("rsvd_busy", bus.busy, 0);
         checkOutput("rsvd_hi", bus.hi, mHi);
         checkOutput("rsvd_lo", bus.lo, mLo);
      end
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          pick;
      logic        sawDone;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a     = '0;
      bus.b     = '0;
      mHi = '0;
      mLo = '0;
      mDz = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_dz", bus.div_zero, 0);
      checkOutput("rst_hi", bus.hi, 0);
      checkOutput("rst_lo", bus.lo, 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      checkOutput("multu_ff_hi", bus.hi, 64'hFFFF_FFFE);
      checkOutput("multu_ff_lo", bus.lo, 64'h1);
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", bus.done, 0);

      applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
      checkOutput("mult_neg_lo", bus.lo, 64'hFFFF_FFEB);
      applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      checkOutput("mult_min_hi", bus.hi, 64'h4000_0000);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      checkOutput("div_neg_lo", bus.lo, 64'hFFFF_FFFD);
      applyStimulus(OP_DIVU, 32'd7, 32'd2, 0);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      checkOutput("div_ovf_lo", bus.lo, 64'h8000_0000);
      applyStimulus(OP_DIVU, 32'h1234, 32'd0, 0);
      checkOutput("divz_hi", bus.hi, 64'h1234);
      applyStimulus(OP_DIV, 32'hFFFF_FF00, 32'd0, 0);
      applyStimulus(OP_MULTU, 32'd5, 32'd6, 10);
      checkOutput("ignored_start_lo", bus.lo, 64'd30);
      applyStimulus(OP_MTLO, 32'hABCD, 32'd0, 0);
      applyStimulus(OP_RSVD, 32'h1111, 32'h2222, 0);
      applyStimulus(OP_MTHI, 32'h5A5A, 32'd0, 0);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_hi", bus.hi, 0);
      checkOutput("midrst_lo", bus.lo, 0);
      @(negedge clk);
      rst = 1'b0;
      mHi = '0;
      mLo = '0;
      mDz = 1'b0;
      sawDone = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) sawDone = 1'b1;
      end
      checkOutput("midrst_no_done", sawDone, 0);
      applyStimulus(OP_MULTU, 32'd2, 32'd3, 0);

      for (int i = 0; i < 30; i++) begin
         rop  = 3'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         pick = $urandom_range(0, 7);
         if (pick == 0) rb = 32'd0;
         else if (pick == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end else if (pick == 2) rb = 32'($urandom_range(1, 255));
         applyStimulus(rop, ra, rb, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
